// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: round-robin between instruction fetch (IF) and load/store (LS).
// Optional response timeout is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_done_o,
    output logic              if_err_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [3:0]        ls_be_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    output logic              ls_done_o,
    output logic              ls_err_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_err_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

    state_t            state_q;
    owner_t            owner_q;
    owner_t            lastOwner_q;
    logic              cmdWe_q;
    logic [3:0]        cmdBe_q;
    logic [ADDR_W-1:0] cmdAddr_q;
    logic [DATA_W-1:0] cmdWdata_q;

    logic grantLs;
    logic respDone;
    logic timeoutHit;
    logic anyDone;

    // On a tie the requester that did not own the bus last time wins.
    assign grantLs  = ls_req_i && (!if_req_i || (lastOwner_q == OWN_IF));
    assign respDone = (state_q == ST_WAIT) && mem_rvalid_i;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] timeoutCnt_q;

    // A real response in the same cycle as the limit still completes normally.
    assign timeoutHit = (state_q != ST_IDLE) && !respDone
                        && (timeoutCnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeoutCnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            timeoutCnt_q <= '0;
        end else begin
            timeoutCnt_q <= timeoutCnt_q + CNT_W'(1);
        end
    end
`else
    assign timeoutHit = (TIMEOUT_CYCLES < 0);
`endif

    assign anyDone = respDone || timeoutHit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            lastOwner_q <= OWN_IF;
            cmdWe_q     <= 1'b0;
            cmdBe_q     <= 4'h0;
            cmdAddr_q   <= '0;
            cmdWdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (if_req_i || ls_req_i) begin
                        state_q <= ST_REQ;
                        if (grantLs) begin
                            owner_q     <= OWN_LS;
                            lastOwner_q <= OWN_LS;
                            cmdWe_q     <= ls_we_i;
                            cmdBe_q     <= ls_be_i;
                            cmdAddr_q   <= ls_addr_i;
                            cmdWdata_q  <= ls_wdata_i;
                        end else begin
                            owner_q     <= OWN_IF;
                            lastOwner_q <= OWN_IF;
                            cmdWe_q     <= 1'b0;
                            cmdBe_q     <= 4'hF;
                            cmdAddr_q   <= if_addr_i;
                            cmdWdata_q  <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (timeoutHit) begin
                        state_q <= ST_IDLE;
                    end else if (mem_gnt_i) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (anyDone) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Completion is steered combinationally to whichever side owns the bus.
    assign if_done_o  = anyDone && (owner_q == OWN_IF);
    assign ls_done_o  = anyDone && (owner_q == OWN_LS);
    assign if_err_o   = if_done_o && (respDone ? mem_err_i : 1'b1);
    assign ls_err_o   = ls_done_o && (respDone ? mem_err_i : 1'b1);
    assign if_rdata_o = (if_done_o && respDone) ? mem_rdata_i : '0;
    assign ls_rdata_o = (ls_done_o && respDone) ? mem_rdata_i : '0;

    assign mem_req_o   = (state_q == ST_REQ) && !timeoutHit;
    assign mem_we_o    = cmdWe_q;
    assign mem_be_o    = cmdBe_q;
    assign mem_addr_o  = cmdAddr_q;
    assign mem_wdata_o = cmdWdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus a hand-written reset-in-WAIT sequence.
// The timeout section only runs when MEM_ARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 8).
module tb_mem_arbiter;

    localparam logic [1:0] CMD_ZERO = 2'd0;
    localparam logic [1:0] CMD_IF   = 2'd1;
    localparam logic [1:0] CMD_LS   = 2'd2;
    localparam logic [1:0] CMD_ANY  = 2'd3;

    typedef struct {
        logic        ifReq;
        logic [31:0] ifAddr;
        logic        lsReq;
        logic        lsWe;
        logic [3:0]  lsBe;
        logic [31:0] lsAddr;
        logic [31:0] lsWdata;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        merr;
        logic        expReq;
        logic [1:0]  expCmd;
        logic        expIfDone;
        logic        expIfErr;
        logic        expLsDone;
        logic        expLsErr;
        logic [31:0] expRdata;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        ifDone;
    logic        ifErr;
    logic [31:0] ifRdata;
    logic        lsReq;
    logic        lsWe;
    logic [3:0]  lsBe;
    logic [31:0] lsAddr;
    logic [31:0] lsWdata;
    logic        lsDone;
    logic        lsErr;
    logic [31:0] lsRdata;
    logic        memReq;
    logic        memWe;
    logic [3:0]  memBe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memGnt;
    logic        memRvalid;
    logic [31:0] memRdata;
    logic        memErr;

    int totalCount;
    int badCount;

    logic [31:0] curIfAddr;
    logic        curLsWe;
    logic [3:0]  curLsBe;
    logic [31:0] curLsAddr;
    logic [31:0] curLsWdata;

    vec_t vecs[$];

    mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req_i(ifReq),
        .if_addr_i(ifAddr),
        .if_done_o(ifDone),
        .if_err_o(ifErr),
        .if_rdata_o(ifRdata),
        .ls_req_i(lsReq),
        .ls_we_i(lsWe),
        .ls_be_i(lsBe),
        .ls_addr_i(lsAddr),
        .ls_wdata_i(lsWdata),
        .ls_done_o(lsDone),
        .ls_err_o(lsErr),
        .ls_rdata_o(lsRdata),
        .mem_req_o(memReq),
        .mem_we_o(memWe),
        .mem_be_o(memBe),
        .mem_addr_o(memAddr),
        .mem_wdata_o(memWdata),
        .mem_gnt_i(memGnt),
        .mem_rvalid_i(memRvalid),
        .mem_rdata_i(memRdata),
        .mem_err_i(memErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic addVec(input logic rIfReq, input logic rLsReq, input logic rGnt, input logic rRvalid,
                          input logic [31:0] rRdata, input logic rMerr, input logic eReq, input logic [1:0] eCmd,
                          input logic eIfDone, input logic eIfErr, input logic eLsDone, input logic eLsErr,
                          input logic [31:0] eRdata);
        vec_t v;
        v.ifReq = rIfReq;      v.ifAddr = curIfAddr;
        v.lsReq = rLsReq;      v.lsWe = curLsWe;       v.lsBe = curLsBe;
        v.lsAddr = curLsAddr;  v.lsWdata = curLsWdata;
        v.gnt = rGnt;          v.rvalid = rRvalid;     v.rdata = rRdata;   v.merr = rMerr;
        v.expReq = eReq;       v.expCmd = eCmd;
        v.expIfDone = eIfDone; v.expIfErr = eIfErr;
        v.expLsDone = eLsDone; v.expLsErr = eLsErr;
        v.expRdata = eRdata;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        ifReq     = v.ifReq;
        ifAddr    = v.ifAddr;
        lsReq     = v.lsReq;
        lsWe      = v.lsWe;
        lsBe      = v.lsBe;
        lsAddr    = v.lsAddr;
        lsWdata   = v.lsWdata;
        memGnt    = v.gnt;
        memRvalid = v.rvalid;
        memRdata  = v.rdata;
        memErr    = v.merr;
    endtask

    task automatic checkRow(input string tag, input int idx, input vec_t v);
        string p;
        p = $sformatf("%s[%0d]", tag, idx);
        checkOutput({p, ".if_done"},  32'(ifDone),  32'(v.expIfDone));
        checkOutput({p, ".if_err"},   32'(ifErr),   32'(v.expIfErr));
        checkOutput({p, ".if_rdata"}, ifRdata,      v.expIfDone ? v.expRdata : 32'h0);
        checkOutput({p, ".ls_done"},  32'(lsDone),  32'(v.expLsDone));
        checkOutput({p, ".ls_err"},   32'(lsErr),   32'(v.expLsErr));
        checkOutput({p, ".ls_rdata"}, lsRdata,      v.expLsDone ? v.expRdata : 32'h0);
        checkOutput({p, ".mem_req"},  32'(memReq),  32'(v.expReq));
        if (v.expCmd != CMD_ANY) begin
            logic        eWe;
            logic [3:0]  eBe;
            logic [31:0] eAddr;
            logic [31:0] eWdata;
            case (v.expCmd)
                CMD_IF:  begin eWe = 1'b0;   eBe = 4'hF;   eAddr = v.ifAddr; eWdata = 32'h0; end
                CMD_LS:  begin eWe = v.lsWe; eBe = v.lsBe; eAddr = v.lsAddr; eWdata = v.lsWdata; end
                default: begin eWe = 1'b0;   eBe = 4'h0;   eAddr = 32'h0;    eWdata = 32'h0; end
            endcase
            checkOutput({p, ".mem_we"},    32'(memWe), 32'(eWe));
            checkOutput({p, ".mem_be"},    32'(memBe), 32'(eBe));
            checkOutput({p, ".mem_addr"},  memAddr,    eAddr);
            checkOutput({p, ".mem_wdata"}, memWdata,   eWdata);
        end
    endtask

    task automatic runVecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkRow(tag, i, vecs[i]);
        end
        vecs.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".if_done"},   32'(ifDone),  32'h0);
        checkOutput({tag, ".if_err"},    32'(ifErr),   32'h0);
        checkOutput({tag, ".if_rdata"},  ifRdata,      32'h0);
        checkOutput({tag, ".ls_done"},   32'(lsDone),  32'h0);
        checkOutput({tag, ".ls_err"},    32'(lsErr),   32'h0);
        checkOutput({tag, ".ls_rdata"},  lsRdata,      32'h0);
        checkOutput({tag, ".mem_req"},   32'(memReq),  32'h0);
        checkOutput({tag, ".mem_we"},    32'(memWe),   32'h0);
        checkOutput({tag, ".mem_be"},    32'(memBe),   32'h0);
        checkOutput({tag, ".mem_addr"},  memAddr,      32'h0);
        checkOutput({tag, ".mem_wdata"}, memWdata,     32'h0);
    endtask

    initial begin
        totalCount = 0;
        badCount   = 0;
        rst = 1'b1;
        ifReq = 1'b0; ifAddr = 32'h0; lsReq = 1'b0; lsWe = 1'b0; lsBe = 4'h0;
        lsAddr = 32'h0; lsWdata = 32'h0; memGnt = 1'b0; memErr = 1'b0;
        memRvalid = 1'b1; memRdata = 32'hFFFF_FFFF;

        // Round-robin from reset: both held for four transactions, LS first.
        curIfAddr = 32'h0000_0400; curLsWe = 1'b1; curLsBe = 4'b1100;
        curLsAddr = 32'h0000_0800; curLsWdata = 32'hAAAA_5555;
        addVec(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_ZERO, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, CMD_LS,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b1, 1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, CMD_LS,   1'b0, 1'b0, 1'b1, 1'b0, 32'h1111_1111);
        addVec(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_LS,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, CMD_IF,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b1, 1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, CMD_IF,   1'b1, 1'b0, 1'b0, 1'b0, 32'h2222_2222);
        addVec(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_IF,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, CMD_LS,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b1, 1'b0, 1'b1, 32'h3333_3333, 1'b0, 1'b0, CMD_LS,   1'b0, 1'b0, 1'b1, 1'b0, 32'h3333_3333);
        addVec(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_LS,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, CMD_IF,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b1, 1'b0, 1'b1, 32'h4444_4444, 1'b0, 1'b0, CMD_IF,   1'b1, 1'b0, 1'b0, 1'b0, 32'h4444_4444);
        addVec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_IF,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // IF-only read at 0x100 with minimum latency.
        curIfAddr = 32'h0000_0100;
        addVec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_ANY,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, CMD_IF,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, CMD_IF,   1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        addVec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_IF,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // LS store with grant withheld three cycles: command stable across four REQ cycles.
        curLsWe = 1'b1; curLsBe = 4'b0011; curLsAddr = 32'h0000_2000; curLsWdata = 32'h0000_1234;
        addVec(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_ANY,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, CMD_LS,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, CMD_LS,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, CMD_LS,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, CMD_LS,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_LS,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, CMD_LS,   1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_LS,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // LS load with error; stray rvalid in IDLE and rvalid alongside gnt in REQ are ignored.
        curIfAddr = 32'h0000_0500;
        curLsWe = 1'b0; curLsBe = 4'hF; curLsAddr = 32'h0000_3000; curLsWdata = 32'h0;
        addVec(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_5555, 1'b0, 1'b0, CMD_ANY,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_5555, 1'b0, 1'b1, CMD_LS,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0, CMD_LS,   1'b0, 1'b0, 1'b1, 1'b1, 32'h0BAD_F00D);
        addVec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_LS,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, CMD_IF,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, CMD_IF,   1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D);
        addVec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_IF,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset values are visible while reset is held, even with a response driven.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        memRvalid = 1'b0; memRdata = 32'h0;
        rst = 1'b0;

        runVecs("main");

        // Reset asserted during WAIT aborts the transaction without a done.
        curIfAddr = 32'h0000_0600;
        addVec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_ANY,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, CMD_IF,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        runVecs("preRst");
        @(posedge clk);
        #1;
        memGnt = 1'b0; memRvalid = 1'b1; memRdata = 32'h7777_7777;
        #1;
        checkOutput("rstWait.if_done_before", 32'(ifDone), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("rstWait");
        @(negedge clk);
        ifReq = 1'b0; memRvalid = 1'b0; memRdata = 32'h0;
        @(negedge clk);
        checkAllZero("rstHeld");
        rst = 1'b0;

        curIfAddr = 32'h0000_0700;
        addVec(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_ZERO, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, CMD_IF,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b1, 1'b0, 1'b0, 1'b1, 32'h8888_8888, 1'b0, 1'b0, CMD_IF,   1'b1, 1'b0, 1'b0, 1'b0, 32'h8888_8888);
        addVec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_IF,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        runVecs("postRst");

`ifdef MEM_ARB_TIMEOUT_EN
        // Granted but never answered: abort lands 8 cycles after REQ entry; late rvalid is dropped.
        curLsWe = 1'b0; curLsBe = 4'hF; curLsAddr = 32'h0000_4000; curLsWdata = 32'h0;
        addVec(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_ANY,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, CMD_LS,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 7; i++) begin
            addVec(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, CMD_LS, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        addVec(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, CMD_LS,   1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        addVec(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0099, 1'b0, 1'b0, CMD_LS,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        addVec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, CMD_LS,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        runVecs("timeout");
`endif

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
